// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sequencer slice.
//   TIME_W        : width of a BCD HH:MM time word {h1,h0,m1,m0}
//   alarm_state_t : alarm lifecycle state, 2-bit encoding
package alarm_pkg;

  localparam int unsigned TIME_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RINGING   = 2'd1,
    ST_SNOOZING  = 2'd2,
    ST_DISMISSED = 2'd3
  } alarm_state_t;

endpackage

// File: rtl/alarm_sequencer_minute_countdown.sv
// minute_countdown: 4-bit loadable down-counter stepped by the one-minute
// strobe. It holds at zero and never wraps.
// Ports:
//   clk256   : 256 Hz clock
//   reset_n  : asynchronous active-low reset
//   clear    : synchronous clear to 0 (highest priority)
//   load     : synchronous load of load_val
//   load_val : value loaded when load is high
//   dec      : decrement by one (ignored at zero)
//   count    : current count
//   zero     : high when count is 0
module minute_countdown (
  input  logic       clk256,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);

  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: compares the current time with the stored alarm time and
// runs the alarm lifecycle (idle, ringing, snoozing, dismissed), including
// ring timeout and the per-event snooze budget.
// Optional build macro: ALARM_BEEP_EN -- when defined, sound_alarm pulses
// 1 s on / 1 s off while ringing (starting on); otherwise it is steady.
// Ports:
//   clk256        : 256 Hz clock, all state on rising edge
//   reset_n       : asynchronous active-low reset
//   one_second    : 1 Hz single-cycle strobe (beep phase only)
//   one_minute    : once-per-minute single-cycle strobe
//   alarm_enable  : level, alarm armed when high
//   snooze        : single-cycle snooze button pulse
//   stop_alarm    : single-cycle stop button pulse
//   current_time  : BCD HH:MM
//   alarm_time    : BCD HH:MM
//   sound_alarm   : buzzer/LED drive
//   ringing       : high while ringing
//   snoozing      : high while snoozing
//   snooze_left   : minutes left in the current snooze, else 0
//   snoozes_used  : snoozes taken in the current alarm event
module alarm_sequencer #(
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned RING_TIMEOUT_MIN = 10,
  parameter int unsigned MAX_SNOOZES      = 3
) (
  input  logic        clk256,
  input  logic        reset_n,
  input  logic        one_second,
  input  logic        one_minute,
  input  logic        alarm_enable,
  input  logic        snooze,
  input  logic        stop_alarm,
  input  logic [15:0] current_time,
  input  logic [15:0] alarm_time,
  output logic        sound_alarm,
  output logic        ringing,
  output logic        snoozing,
  output logic [3:0]  snooze_left,
  output logic [1:0]  snoozes_used
);

  import alarm_pkg::*;

  localparam logic [3:0] SNOOZE_LEN  = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LIMIT  = 4'(RING_TIMEOUT_MIN);
  localparam logic [1:0] SNOOZE_CAP  = 2'(MAX_SNOOZES);

  alarm_state_t state, state_nx;
  logic [3:0]   ring_cnt, ring_cnt_nx;
  logic [1:0]   used, used_nx;
  logic         cd_clear, cd_load, cd_dec, cd_zero;
  logic [3:0]   cd_count;
  logic [TIME_W-1:0] cur_w, alm_w;
  logic         match;

  assign cur_w = current_time;
  assign alm_w = alarm_time;
  assign match = (cur_w == alm_w);

  minute_countdown u_snooze_timer (
    .clk256   (clk256),
    .reset_n  (reset_n),
    .clear    (cd_clear),
    .load     (cd_load),
    .load_val (SNOOZE_LEN),
    .dec      (cd_dec),
    .count    (cd_count),
    .zero     (cd_zero)
  );

  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ring_cnt <= '0;
      used     <= '0;
    end else begin
      state    <= state_nx;
      ring_cnt <= ring_cnt_nx;
      used     <= used_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ring_cnt_nx = ring_cnt;
    used_nx     = used;
    cd_clear    = 1'b0;
    cd_load     = 1'b0;
    cd_dec      = 1'b0;
    if (!alarm_enable) begin
      state_nx    = ST_IDLE;
      ring_cnt_nx = '0;
      used_nx     = '0;
      cd_clear    = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (match) begin
            state_nx    = ST_RINGING;
            ring_cnt_nx = '0;
            used_nx     = '0;
          end
        end
        ST_RINGING: begin
          if (stop_alarm) begin
            state_nx = ST_DISMISSED;
          end else if (snooze && (used < SNOOZE_CAP)) begin
            state_nx    = ST_SNOOZING;
            used_nx     = used + 2'd1;
            ring_cnt_nx = '0;
            cd_load     = 1'b1;
          end else if (snooze) begin
            // budget exhausted: the pulse is swallowed, nothing changes
            state_nx = ST_RINGING;
          end else if (one_minute) begin
            ring_cnt_nx = ring_cnt + 4'd1;
            if ((ring_cnt + 4'd1) == RING_LIMIT) begin
              state_nx = ST_DISMISSED;
            end
          end
        end
        ST_SNOOZING: begin
          if (stop_alarm) begin
            state_nx = ST_DISMISSED;
            cd_clear = 1'b1;
          end else if (one_minute && !cd_zero) begin
            cd_dec = 1'b1;
            if (cd_count == 4'd1) begin
              state_nx    = ST_RINGING;
              ring_cnt_nx = '0;
            end
          end
        end
        ST_DISMISSED: begin
          // wait out the alarm minute so the same match cannot re-trigger
          if (!match) begin
            state_nx = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign ringing      = (state == ST_RINGING);
  assign snoozing     = (state == ST_SNOOZING);
  assign snooze_left  = snoozing ? cd_count : '0;
  assign snoozes_used = used;

`ifdef ALARM_BEEP_EN
  logic phase;

  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 1'b0;
    end else if ((state_nx == ST_RINGING) && (state != ST_RINGING)) begin
      phase <= 1'b1;
    end else if ((state == ST_RINGING) && one_second) begin
      phase <= ~phase;
    end
  end

  assign sound_alarm = ringing && phase;
`else
  logic unused_one_second;
  assign unused_one_second = one_second;
  assign sound_alarm       = ringing;
`endif

endmodule
